// File: rtl/exception_redirect_ctrl.sv
// Commit-stage exception arbiter: picks the winning cause, produces the CP0 update,
// and sequences the PC redirect to IF through a drain-then-handshake FSM.
module exception_redirect_ctrl #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC0_0200,
    parameter logic [31:0] VEC_BEV0 = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [18:0] MEM_ExceptVec,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_IsInDelaySlot,
    input  logic [31:0] MEM_BadVAddr,
    input  logic        CP0_Status_EXL,
    input  logic        CP0_Status_BEV,
    input  logic [31:0] CP0_EPC,
    input  logic        IF_ReqPending,
    input  logic        Redirect_Ready,
    output logic        Flush_Pipe,
    output logic        Stall_IF,
    output logic        CP0_ExcWr,
    output logic [4:0]  CP0_ExcCode,
    output logic        CP0_BD,
    output logic [31:0] CP0_EPCOut,
    output logic        CP0_BadVAddrWr,
    output logic [31:0] CP0_BadVAddrOut,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    output logic [31:0] Exc_Count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [4:0]  winner;
    logic        fire;
    logic        busy;
    logic        handshake;
    logic        is_eret;
    logic        is_refetch;
    logic        is_refill;
    logic [4:0]  exc_code;
    logic        badv_hit;
    logic [31:0] badv_val;
    logic [31:0] base;
    logic [31:0] target;

    // Lowest set bit wins; scanning downward leaves the smallest index last.
    always_comb begin
        winner = 5'd0;
        for (int i = 18; i >= 0; i--) begin
            if (MEM_ExceptVec[i]) winner = 5'(i);
        end
    end

    assign fire       = !rst && (state == ST_IDLE) && MEM_Valid && (|MEM_ExceptVec);
    assign busy       = !rst && (state != ST_IDLE);
    assign handshake  = (state == ST_REDIR) && Redirect_Ready;
    assign is_eret    = (winner == 5'd8);
    assign is_refetch = (winner == 5'd18);
    assign is_refill  = (winner == 5'd2) || (winner == 5'd13) || (winner == 5'd15);

    always_comb begin
        exc_code = 5'h00;
        badv_hit = 1'b0;
        badv_val = 32'd0;
        case (winner)
            5'd0:  exc_code = 5'h00;
            5'd1:  begin exc_code = 5'h04; badv_hit = 1'b1; badv_val = MEM_PC; end
            5'd2:  begin exc_code = 5'h02; badv_hit = 1'b1; badv_val = MEM_PC; end
            5'd3:  begin exc_code = 5'h02; badv_hit = 1'b1; badv_val = MEM_PC; end
            5'd4:  exc_code = 5'h0A;
            5'd5:  exc_code = 5'h0B;
            5'd6:  exc_code = 5'h08;
            5'd7:  exc_code = 5'h09;
            5'd9:  exc_code = 5'h0C;
            5'd10: exc_code = 5'h0D;
            5'd11: begin exc_code = 5'h04; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            5'd12: begin exc_code = 5'h05; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            5'd13: begin exc_code = 5'h02; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            5'd14: begin exc_code = 5'h02; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            5'd15: begin exc_code = 5'h03; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            5'd16: begin exc_code = 5'h03; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            5'd17: begin exc_code = 5'h01; badv_hit = 1'b1; badv_val = MEM_BadVAddr; end
            default: exc_code = 5'h00;
        endcase
    end

    // Refills with EXL clear use the dedicated vector at the base; everything else goes to +0x180.
    assign base = CP0_Status_BEV ? VEC_BEV1 : VEC_BEV0;

    always_comb begin
        if (is_eret)                          target = CP0_EPC;
        else if (is_refetch)                  target = MEM_PC + 32'd4;
        else if (is_refill && !CP0_Status_EXL) target = base;
        else                                  target = base + 32'h0000_0180;
    end

    assign CP0_ExcWr       = fire && !is_eret && !is_refetch;
    assign CP0_ExcCode     = fire ? exc_code : 5'h00;
    assign CP0_BD          = fire && MEM_IsInDelaySlot;
    assign CP0_EPCOut      = !fire ? 32'd0 : (MEM_IsInDelaySlot ? MEM_PC - 32'd4 : MEM_PC);
    assign CP0_BadVAddrWr  = fire && badv_hit;
    assign CP0_BadVAddrOut = fire ? badv_val : 32'd0;

    assign Flush_Pipe     = fire || busy;
    assign Stall_IF       = fire || busy;
    assign Redirect_Valid = !rst && (state == ST_REDIR);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fire) state_next = IF_ReqPending ? ST_DRAIN : ST_REDIR;
            ST_DRAIN: if (!IF_ReqPending) state_next = ST_REDIR;
            ST_REDIR: if (Redirect_Ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Redirect target is captured at fire so later MEM traffic cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            Redirect_PC <= 32'd0;
            Exc_Count   <= 32'd0;
        end else begin
            state <= state_next;
            if (fire)      Redirect_PC <= target;
            if (handshake) Exc_Count   <= Exc_Count + 32'd1;
        end
    end

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// Self-checking bench for exception_redirect_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level model of cause selection and redirect targets.
module tb_exception_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Valid;
    logic [18:0] MEM_ExceptVec;
    logic [31:0] MEM_PC;
    logic        MEM_IsInDelaySlot;
    logic [31:0] MEM_BadVAddr;
    logic        CP0_Status_EXL;
    logic        CP0_Status_BEV;
    logic [31:0] CP0_EPC;
    logic        IF_ReqPending;
    logic        Redirect_Ready;
    logic        Flush_Pipe;
    logic        Stall_IF;
    logic        CP0_ExcWr;
    logic [4:0]  CP0_ExcCode;
    logic        CP0_BD;
    logic [31:0] CP0_EPCOut;
    logic        CP0_BadVAddrWr;
    logic [31:0] CP0_BadVAddrOut;
    logic        Redirect_Valid;
    logic [31:0] Redirect_PC;
    logic [31:0] Exc_Count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_count = 32'd0;

    int code_tab [0:18] = '{0, 4, 2, 2, 10, 11, 8, 9, -1, 12, 13, 4, 5, 2, 2, 3, 3, 1, -1};

    exception_redirect_ctrl dut (
        .clk(clk), .rst(rst),
        .MEM_Valid(MEM_Valid), .MEM_ExceptVec(MEM_ExceptVec), .MEM_PC(MEM_PC),
        .MEM_IsInDelaySlot(MEM_IsInDelaySlot), .MEM_BadVAddr(MEM_BadVAddr),
        .CP0_Status_EXL(CP0_Status_EXL), .CP0_Status_BEV(CP0_Status_BEV), .CP0_EPC(CP0_EPC),
        .IF_ReqPending(IF_ReqPending), .Redirect_Ready(Redirect_Ready),
        .Flush_Pipe(Flush_Pipe), .Stall_IF(Stall_IF), .CP0_ExcWr(CP0_ExcWr),
        .CP0_ExcCode(CP0_ExcCode), .CP0_BD(CP0_BD), .CP0_EPCOut(CP0_EPCOut),
        .CP0_BadVAddrWr(CP0_BadVAddrWr), .CP0_BadVAddrOut(CP0_BadVAddrOut),
        .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC), .Exc_Count(Exc_Count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Model: isolate the lowest set bit arithmetically, then name its position.
    function automatic int model_winner(logic [18:0] v);
        logic [18:0] low;
        low = v & (~v + 19'd1);
        for (int i = 0; i < 19; i++) if (low == (19'd1 << i)) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_target(int w, logic [31:0] pc, logic exl, logic bev, logic [31:0] epc);
        logic [31:0] b;
        b = bev ? 32'hBFC0_0200 : 32'h8000_0000;
        if (w == 8) return epc;
        if (w == 18) return pc + 32'd4;
        if ((w == 2 || w == 13 || w == 15) && !exl) return b;
        return b + 32'h180;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [18:0] vec, input logic [31:0] pc,
                                 input logic bd, input logic [31:0] bad);
        MEM_Valid = v;
        MEM_ExceptVec = vec;
        MEM_PC = pc;
        MEM_IsInDelaySlot = bd;
        MEM_BadVAddr = bad;
    endtask

    task automatic set_idle();
        applyStimulus(1'b0, 19'd0, 32'd0, 1'b0, 32'd0);
        IF_ReqPending = 1'b0;
        Redirect_Ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        CP0_Status_EXL = 1'b0; CP0_Status_BEV = 1'b0; CP0_EPC = 32'd0;
        applyStimulus(1'b1, 19'h40, 32'h8000_0000, 1'b0, 32'd0);
        IF_ReqPending = 1'b0; Redirect_Ready = 1'b1;
        tick(); tick(); #1;
        checks++; if (CP0_ExcWr !== 1'b0) begin errors++; $display("[TB] FAIL rst_excwr: got %0h exp 0", CP0_ExcWr); end
        checks++; if (Redirect_Valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rvalid: got %0h exp 0", Redirect_Valid); end
        tick(); rst = 1'b0; set_idle(); #1;
        checks++; if (Redirect_PC !== 32'd0) begin errors++; $display("[TB] FAIL rst_rpc: got %0h exp 0", Redirect_PC); end
        checks++; if (Exc_Count !== 32'd0) begin errors++; $display("[TB] FAIL rst_count: got %0h exp 0", Exc_Count); end
        checks++; if (Stall_IF !== 1'b0 || Flush_Pipe !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_flush: got %0h/%0h exp 0/0", Stall_IF, Flush_Pipe); end
    endtask

    task automatic test_reset_abort();
        tick(); applyStimulus(1'b1, 19'd1 << 18, 32'h8000_5000, 1'b0, 32'd0); #1;
        checks++; if (Flush_Pipe !== 1'b1) begin errors++; $display("[TB] FAIL abort_fire_flush: got %0h exp 1", Flush_Pipe); end
        tick(); set_idle(); #1;
        checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== 32'h8000_5004) begin errors++; $display("[TB] FAIL abort_redir: got %0h/%0h exp 1/80005004", Redirect_Valid, Redirect_PC); end
        tick(); rst = 1'b1; Redirect_Ready = 1'b1;
        tick(); rst = 1'b0; Redirect_Ready = 1'b0; #1;
        checks++; if (Redirect_Valid !== 1'b0 || Stall_IF !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got rv=%0h stall=%0h exp 0/0", Redirect_Valid, Stall_IF); end
        checks++; if (Exc_Count !== exp_count) begin errors++; $display("[TB] FAIL abort_count: got %0h exp %0h", Exc_Count, exp_count); end
    endtask

    task automatic test_priority();
        CP0_Status_EXL = 1'b0; CP0_Status_BEV = 1'b0;
        tick(); applyStimulus(1'b1, (19'd1 << 6) | (19'd1 << 9), 32'h8000_1000, 1'b0, 32'hDEAD_BEEF); #1;
        checks++; if (CP0_ExcWr !== 1'b1) begin errors++; $display("[TB] FAIL prio_excwr: got %0h exp 1", CP0_ExcWr); end
        checks++; if (CP0_ExcCode !== 5'h08) begin errors++; $display("[TB] FAIL prio_code: got %0h exp 8", CP0_ExcCode); end
        checks++; if (CP0_EPCOut !== 32'h8000_1000) begin errors++; $display("[TB] FAIL prio_epc: got %0h exp 80001000", CP0_EPCOut); end
        checks++; if (CP0_BadVAddrWr !== 1'b0) begin errors++; $display("[TB] FAIL prio_badvwr: got %0h exp 0", CP0_BadVAddrWr); end
        tick(); set_idle(); Redirect_Ready = 1'b1; #1;
        checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== 32'h8000_0180) begin errors++; $display("[TB] FAIL prio_redir: got %0h/%0h exp 1/80000180", Redirect_Valid, Redirect_PC); end
        exp_count++;
        tick(); Redirect_Ready = 1'b0; #1;
        checks++; if (Exc_Count !== exp_count || Redirect_Valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_done: got cnt=%0h rv=%0h exp %0h/0", Exc_Count, Redirect_Valid, exp_count); end
    endtask

    task automatic test_tlb_refill();
        for (int exl = 0; exl < 2; exl++) begin
            CP0_Status_EXL = exl[0];
            tick(); applyStimulus(1'b1, 19'd1 << 13, 32'h8000_2004, 1'b1, 32'h0040_0003); #1;
            checks++; if (CP0_ExcCode !== 5'h02 || CP0_BD !== 1'b1) begin errors++; $display("[TB] FAIL refill_code_bd: got %0h/%0h exp 2/1", CP0_ExcCode, CP0_BD); end
            checks++; if (CP0_BadVAddrWr !== 1'b1 || CP0_BadVAddrOut !== 32'h0040_0003) begin errors++; $display("[TB] FAIL refill_badv: got %0h/%0h exp 1/00400003", CP0_BadVAddrWr, CP0_BadVAddrOut); end
            checks++; if (CP0_EPCOut !== 32'h8000_2000) begin errors++; $display("[TB] FAIL refill_epc: got %0h exp 80002000", CP0_EPCOut); end
            tick(); set_idle(); Redirect_Ready = 1'b1; #1;
            checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== (exl == 0 ? 32'h8000_0000 : 32'h8000_0180)) begin errors++; $display("[TB] FAIL refill_target exl=%0d: got %0h/%0h", exl, Redirect_Valid, Redirect_PC); end
            exp_count++;
            tick(); Redirect_Ready = 1'b0; #1;
        end
        CP0_Status_EXL = 1'b0;
    endtask

    task automatic test_eret();
        CP0_EPC = 32'hBFC0_0380;
        tick(); applyStimulus(1'b1, 19'd1 << 8, 32'h8000_4000, 1'b0, 32'd0); #1;
        checks++; if (CP0_ExcWr !== 1'b0 || Flush_Pipe !== 1'b1) begin errors++; $display("[TB] FAIL eret_fire: got excwr=%0h flush=%0h exp 0/1", CP0_ExcWr, Flush_Pipe); end
        tick(); set_idle(); Redirect_Ready = 1'b1; #1;
        checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== 32'hBFC0_0380) begin errors++; $display("[TB] FAIL eret_target: got %0h/%0h exp 1/bfc00380", Redirect_Valid, Redirect_PC); end
        exp_count++;
        tick(); Redirect_Ready = 1'b0; #1;
        checks++; if (Exc_Count !== exp_count) begin errors++; $display("[TB] FAIL eret_count: got %0h exp %0h", Exc_Count, exp_count); end
    endtask

    task automatic test_refetch_drain();
        tick(); applyStimulus(1'b1, 19'd1 << 18, 32'h8000_3000, 1'b0, 32'd0); IF_ReqPending = 1'b1; #1;
        checks++; if (CP0_ExcWr !== 1'b0 || Stall_IF !== 1'b1) begin errors++; $display("[TB] FAIL refetch_fire: got excwr=%0h stall=%0h exp 0/1", CP0_ExcWr, Stall_IF); end
        for (int i = 0; i < 3; i++) begin
            tick(); applyStimulus(1'b1, 19'd1 << 6, 32'h1234_5678, 1'b0, 32'd0); IF_ReqPending = (i < 2); #1;
            checks++; if (Redirect_Valid !== 1'b0 || Stall_IF !== 1'b1 || Flush_Pipe !== 1'b1 || CP0_ExcWr !== 1'b0) begin errors++; $display("[TB] FAIL drain_cycle%0d: got rv=%0h stall=%0h flush=%0h excwr=%0h exp 0/1/1/0", i, Redirect_Valid, Stall_IF, Flush_Pipe, CP0_ExcWr); end
        end
        tick(); set_idle(); Redirect_Ready = 1'b1; #1;
        checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== 32'h8000_3004) begin errors++; $display("[TB] FAIL refetch_target: got %0h/%0h exp 1/80003004", Redirect_Valid, Redirect_PC); end
        exp_count++;
        tick(); Redirect_Ready = 1'b0; #1;
    endtask

    task automatic test_ready_stall();
        CP0_Status_BEV = 1'b1;
        tick(); applyStimulus(1'b1, 19'd1, 32'h8000_6000, 1'b0, 32'd0); #1;
        checks++; if (CP0_ExcWr !== 1'b1 || CP0_ExcCode !== 5'h00) begin errors++; $display("[TB] FAIL int_fire: got %0h/%0h exp 1/0", CP0_ExcWr, CP0_ExcCode); end
        for (int i = 0; i < 4; i++) begin
            tick(); applyStimulus(1'b1, 19'($urandom) | 19'd1, $urandom, 1'b0, $urandom); Redirect_Ready = 1'b0; #1;
            checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== 32'hBFC0_0380 || CP0_ExcWr !== 1'b0 || Exc_Count !== exp_count) begin errors++; $display("[TB] FAIL hold_cycle%0d: got rv=%0h pc=%0h excwr=%0h cnt=%0h exp 1/bfc00380/0/%0h", i, Redirect_Valid, Redirect_PC, CP0_ExcWr, Exc_Count, exp_count); end
        end
        tick(); Redirect_Ready = 1'b1; #1;
        exp_count++;
        tick(); set_idle(); #1;
        checks++; if (Exc_Count !== exp_count || Redirect_Valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_done: got cnt=%0h rv=%0h exp %0h/0", Exc_Count, Redirect_Valid, exp_count); end
        CP0_Status_BEV = 1'b0;
    endtask

    task automatic test_invalid();
        tick(); applyStimulus(1'b0, 19'h7FFFF, 32'h8000_7000, 1'b1, 32'h55); #1;
        checks++; if (Flush_Pipe !== 1'b0 || Stall_IF !== 1'b0 || CP0_ExcWr !== 1'b0) begin errors++; $display("[TB] FAIL invalid_fire: got %0h/%0h/%0h exp 0/0/0", Flush_Pipe, Stall_IF, CP0_ExcWr); end
        tick(); set_idle(); #1;
        checks++; if (Redirect_Valid !== 1'b0) begin errors++; $display("[TB] FAIL invalid_rv: got %0h exp 0", Redirect_Valid); end
    endtask

    // Each iteration fires in the cycle right after the previous handshake.
    task automatic test_back_to_back_random();
        logic [18:0] vec;
        logic [31:0] pc, bad, tgt, epc_exp;
        logic v, bd;
        int w, k, drain, delay;
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, 18));
            vec = 19'd1 << k;
            if ($urandom_range(0, 1) == 1) vec = vec | (19'($urandom) << k);
            if ($urandom_range(0, 4) == 0) vec = 19'd0;
            v = ($urandom_range(0, 5) != 0);
            pc = $urandom & 32'hFFFF_FFFC;
            bad = $urandom;
            bd = 1'($urandom_range(0, 1));
            drain = int'($urandom_range(0, 3));
            delay = int'($urandom_range(0, 3));
            tick();
            CP0_Status_EXL = 1'($urandom_range(0, 1));
            CP0_Status_BEV = 1'($urandom_range(0, 1));
            CP0_EPC = $urandom;
            applyStimulus(v, vec, pc, bd, bad); IF_ReqPending = (drain > 0); Redirect_Ready = 1'b0; #1;
            checks++; if (Exc_Count !== exp_count) begin errors++; $display("[TB] FAIL rnd%0d_count: got %0h exp %0h", it, Exc_Count, exp_count); end
            if (!(v && vec != 19'd0)) begin
                checks++; if (Flush_Pipe !== 1'b0 || CP0_ExcWr !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_nofire: got flush=%0h excwr=%0h exp 0/0", it, Flush_Pipe, CP0_ExcWr); end
                continue;
            end
            w = model_winner(vec);
            tgt = model_target(w, pc, CP0_Status_EXL, CP0_Status_BEV, CP0_EPC);
            epc_exp = bd ? pc - 32'd4 : pc;
            checks++; if (Flush_Pipe !== 1'b1 || Stall_IF !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_flush: got %0h/%0h exp 1/1", it, Flush_Pipe, Stall_IF); end
            checks++; if (CP0_ExcWr !== (code_tab[w] >= 0)) begin errors++; $display("[TB] FAIL rnd%0d_excwr w=%0d: got %0h exp %0h", it, w, CP0_ExcWr, code_tab[w] >= 0); end
            if (code_tab[w] >= 0) begin
                checks++; if (CP0_ExcCode !== 5'(code_tab[w]) || CP0_EPCOut !== epc_exp || CP0_BD !== bd) begin errors++; $display("[TB] FAIL rnd%0d_cp0 w=%0d: got code=%0h epc=%0h bd=%0h exp %0h/%0h/%0h", it, w, CP0_ExcCode, CP0_EPCOut, CP0_BD, code_tab[w], epc_exp, bd); end
            end
            checks++; if (CP0_BadVAddrWr !== ((w >= 1 && w <= 3) || (w >= 11 && w <= 17))) begin errors++; $display("[TB] FAIL rnd%0d_badvwr w=%0d: got %0h", it, w, CP0_BadVAddrWr); end
            if (w >= 1 && w <= 3) begin
                checks++; if (CP0_BadVAddrOut !== pc) begin errors++; $display("[TB] FAIL rnd%0d_badv_if: got %0h exp %0h", it, CP0_BadVAddrOut, pc); end
            end else if (w >= 11 && w <= 17) begin
                checks++; if (CP0_BadVAddrOut !== bad) begin errors++; $display("[TB] FAIL rnd%0d_badv_mem: got %0h exp %0h", it, CP0_BadVAddrOut, bad); end
            end
            for (int d = 0; d < drain; d++) begin
                tick(); applyStimulus(1'b1, 19'($urandom) | 19'd1, $urandom, 1'b0, $urandom); IF_ReqPending = (d < drain - 1); #1;
                checks++; if (Redirect_Valid !== 1'b0 || Stall_IF !== 1'b1 || CP0_ExcWr !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_drain%0d: got rv=%0h stall=%0h excwr=%0h exp 0/1/0", it, d, Redirect_Valid, Stall_IF, CP0_ExcWr); end
            end
            for (int r = 0; r <= delay; r++) begin
                tick(); applyStimulus(1'b1, 19'($urandom) | 19'd1, $urandom, 1'b0, $urandom); IF_ReqPending = 1'($urandom_range(0, 1)); Redirect_Ready = (r == delay); #1;
                checks++; if (Redirect_Valid !== 1'b1 || Redirect_PC !== tgt || Flush_Pipe !== 1'b1) begin errors++; $display("[TB] FAIL rnd%0d_redir%0d w=%0d: got rv=%0h pc=%0h flush=%0h exp 1/%0h/1", it, r, w, Redirect_Valid, Redirect_PC, Flush_Pipe, tgt); end
            end
            exp_count++;
        end
        tick(); set_idle(); #1;
        checks++; if (Exc_Count !== exp_count || Redirect_Valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_final: got cnt=%0h rv=%0h exp %0h/0", Exc_Count, Redirect_Valid, exp_count); end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_priority();
        test_tlb_refill();
        test_eret();
        test_refetch_drain();
        test_ready_stall();
        test_invalid();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
